// File: rtl/dtree_seq_pkg.sv
// Shared types and constants for the decision-tree frame sequencer.
// State encodings, default frame geometry and counter width helper.
package dtree_seq_pkg;

  localparam int N_FEAT_D  = 5;
  localparam int FEAT_W_D  = 8;
  localparam int CLASS_W_D = 5;

  typedef logic [1:0] state_t;

  localparam state_t COLLECT = 2'd0;
  localparam state_t DRAIN   = 2'd1;
  localparam state_t EVAL    = 2'd2;
  localparam state_t OUT     = 2'd3;

  // bits needed to count 0..n-1, never less than one
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dtree_feat_bank.sv
// N_FEAT x FEAT_W feature register file, flattened onto the tree bus.
// Single write port by index; synchronous clear wins over write.
module dtree_feat_bank
  import dtree_seq_pkg::*;
#(
  parameter int N_FEAT = N_FEAT_D,
  parameter int FEAT_W = FEAT_W_D,
  parameter int IDX_W  = cnt_w(N_FEAT)
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     we,
  input  logic [IDX_W-1:0]         idx,
  input  logic [FEAT_W-1:0]        wdata,
  output logic [N_FEAT*FEAT_W-1:0] feat
);

  logic [N_FEAT*FEAT_W-1:0] feat_d;
  logic [N_FEAT*FEAT_W-1:0] feat_q;

  always_comb begin
    feat_d = feat_q;
    if (clr) begin
      feat_d = '0;
    end else if (we) begin
      for (int k = 0; k < N_FEAT; k++) begin
        if (idx == IDX_W'(k)) feat_d[k*FEAT_W +: FEAT_W] = wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    feat_q <= feat_d;
  end

  assign feat = feat_q;

endmodule

// File: rtl/dtree_frame_sequencer.sv
// Serial feature collector and result stage for a combinational tree.
// Optional idle timeout on partial frames: DTREE_SEQ_TIMEOUT_EN.
module dtree_frame_sequencer
  import dtree_seq_pkg::*;
#(
  parameter int N_FEAT   = N_FEAT_D,
  parameter int FEAT_W   = FEAT_W_D,
  parameter int CLASS_W  = CLASS_W_D,
  parameter int TREE_LAT = 1,
  parameter int TIMEOUT  = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [FEAT_W-1:0]        s_data,
  input  logic                     s_last,
  output logic [N_FEAT*FEAT_W-1:0] tree_feat,
  input  logic [CLASS_W-1:0]       tree_class,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [CLASS_W-1:0]       m_class,
  output logic                     err,
  output logic                     busy
);

  localparam int CW = cnt_w(N_FEAT);
  localparam int LW = cnt_w(TREE_LAT);
  localparam logic [CW-1:0] LAST_IDX = CW'(N_FEAT - 1);
  localparam logic [LW-1:0] LAT_END  = LW'(TREE_LAT - 1);

  state_t state_d, state_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic [LW-1:0] lat_d, lat_q;
  logic m_valid_d, m_valid_q;
  logic [CLASS_W-1:0] m_class_d, m_class_q;
  logic err_d, err_q;
  logic we;
  logic accept;

`ifdef DTREE_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_END = TW'(TIMEOUT - 1);
  logic [TW-1:0] tmo_d, tmo_q;
`endif

  assign s_ready = (state_q == COLLECT) || (state_q == DRAIN);
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lat_d     = lat_q;
    m_valid_d = m_valid_q;
    m_class_d = m_class_q;
    err_d     = 1'b0;
    we        = 1'b0;
    unique case (state_q)
      COLLECT: begin
        if (accept) begin
          we = 1'b1;
          if (cnt_q == LAST_IDX) begin
            cnt_d = '0;
            if (s_last) begin
              state_d = EVAL;
            end else begin
              err_d   = 1'b1;
              state_d = DRAIN;
            end
          end else if (s_last) begin
            // short frame: keep what was written, launch nothing
            cnt_d = '0;
            err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (accept && s_last) state_d = COLLECT;
      end
      EVAL: begin
        if (lat_q == LAT_END) begin
          lat_d     = '0;
          m_class_d = tree_class;
          m_valid_d = 1'b1;
          state_d   = OUT;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      OUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase

`ifdef DTREE_SEQ_TIMEOUT_EN
    tmo_d = '0;
    if (state_q == COLLECT && cnt_q != '0 && !accept) begin
      if (tmo_q == TMO_END) begin
        cnt_d = '0;
        err_d = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= COLLECT;
      cnt_q     <= '0;
      lat_q     <= '0;
      m_valid_q <= 1'b0;
      m_class_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lat_q     <= lat_d;
      m_valid_q <= m_valid_d;
      m_class_q <= m_class_d;
      err_q     <= err_d;
    end
  end

`ifdef DTREE_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`endif

  dtree_feat_bank #(
    .N_FEAT(N_FEAT),
    .FEAT_W(FEAT_W),
    .IDX_W (CW)
  ) u_bank (
    .clk  (clk),
    .clr  (rst),
    .we   (we),
    .idx  (cnt_q),
    .wdata(s_data),
    .feat (tree_feat)
  );

  assign m_valid = m_valid_q;
  assign m_class = m_class_q;
  assign err     = err_q;
  assign busy    = (state_q != COLLECT) || (cnt_q != '0);

endmodule

// File: tb/tb_dtree_frame_sequencer.sv
// Directed bench for dtree_frame_sequencer: vector table plus sequences.
// Timeout sequence is compiled in with DTREE_SEQ_TIMEOUT_EN.
module tb_dtree_frame_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, s_valid, s_last, m_ready;
  logic [7:0]  s_data;
  logic [4:0]  tree_class;
  logic        s_ready, m_valid, err, busy;
  logic [39:0] tree_feat;
  logic [4:0]  m_class;

  logic        rst_b, s_valid_b, s_last_b, m_ready_b;
  logic [7:0]  s_data_b;
  logic [4:0]  tree_class_b;
  logic        s_ready_b, m_valid_b, err_b, busy_b;
  logic [39:0] tree_feat_b;
  logic [4:0]  m_class_b;

  dtree_frame_sequencer #(.TIMEOUT(8)) u_dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last),
    .tree_feat(tree_feat), .tree_class(tree_class),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_class(m_class), .err(err), .busy(busy)
  );

  dtree_frame_sequencer #(.TREE_LAT(4)) u_lat4 (
    .clk(clk), .rst(rst_b),
    .s_valid(s_valid_b), .s_ready(s_ready_b),
    .s_data(s_data_b), .s_last(s_last_b),
    .tree_feat(tree_feat_b), .tree_class(tree_class_b),
    .m_valid(m_valid_b), .m_ready(m_ready_b),
    .m_class(m_class_b), .err(err_b), .busy(busy_b)
  );

  int n_run = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        mr;
    logic [4:0]  tc;
    logic        sr;
    logic        mv;
    logic [4:0]  mc;
    logic        er;
    logic        bz;
    logic [39:0] feat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    logic v, logic [7:0] d, logic l, logic mr, logic [4:0] tc,
    logic sr, logic mv, logic [4:0] mc, logic er, logic bz,
    logic [39:0] feat);
    vec_t r;
    r.v = v; r.d = d; r.l = l; r.mr = mr; r.tc = tc;
    r.sr = sr; r.mv = mv; r.mc = mc; r.er = er; r.bz = bz;
    r.feat = feat;
    return r;
  endfunction

  initial begin
    // nominal frame, class 17
    vecs.push_back(mk(1, 8'h10, 0, 0, 17, 1, 0, 0, 0, 0, 40'h0));
    vecs.push_back(mk(1, 8'h20, 0, 0, 17, 1, 0, 0, 0, 1, 40'h10));
    vecs.push_back(mk(1, 8'h30, 0, 0, 17, 1, 0, 0, 0, 1, 40'h2010));
    vecs.push_back(mk(1, 8'h40, 0, 0, 17, 1, 0, 0, 0, 1, 40'h302010));
    vecs.push_back(mk(1, 8'h50, 1, 0, 17, 1, 0, 0, 0, 1, 40'h40302010));
    vecs.push_back(mk(0, 8'h00, 0, 0, 17, 0, 0, 0, 0, 1, 40'h5040302010));
    vecs.push_back(mk(0, 8'h00, 0, 0, 17, 0, 1, 17, 0, 1, 40'h5040302010));
    vecs.push_back(mk(0, 8'h00, 0, 1, 17, 0, 1, 17, 0, 1, 40'h5040302010));
    vecs.push_back(mk(0, 8'h00, 0, 0, 17, 1, 0, 17, 0, 0, 40'h5040302010));
    // short frame
    vecs.push_back(mk(1, 8'hA1, 0, 0, 17, 1, 0, 17, 0, 0, 40'h5040302010));
    vecs.push_back(mk(1, 8'hA2, 0, 0, 17, 1, 0, 17, 0, 1, 40'h50403020A1));
    vecs.push_back(mk(1, 8'hA3, 1, 0, 17, 1, 0, 17, 0, 1, 40'h504030A2A1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 17, 1, 0, 17, 1, 0, 40'h5040A3A2A1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 17, 1, 0, 17, 0, 0, 40'h5040A3A2A1));
    // full frame after short one, class 9
    vecs.push_back(mk(1, 8'h01, 0, 0, 9, 1, 0, 17, 0, 0, 40'h5040A3A2A1));
    vecs.push_back(mk(1, 8'h02, 0, 0, 9, 1, 0, 17, 0, 1, 40'h5040A3A201));
    vecs.push_back(mk(1, 8'h03, 0, 0, 9, 1, 0, 17, 0, 1, 40'h5040A30201));
    vecs.push_back(mk(1, 8'h04, 0, 0, 9, 1, 0, 17, 0, 1, 40'h5040030201));
    vecs.push_back(mk(1, 8'h05, 1, 0, 9, 1, 0, 17, 0, 1, 40'h5004030201));
    vecs.push_back(mk(0, 8'h00, 0, 0, 9, 0, 0, 17, 0, 1, 40'h0504030201));
    vecs.push_back(mk(0, 8'h00, 0, 1, 9, 0, 1, 9, 0, 1, 40'h0504030201));
    vecs.push_back(mk(0, 8'h00, 0, 0, 9, 1, 0, 9, 0, 0, 40'h0504030201));
    // long frame, 7 beats
    vecs.push_back(mk(1, 8'h11, 0, 0, 9, 1, 0, 9, 0, 0, 40'h0504030201));
    vecs.push_back(mk(1, 8'h12, 0, 0, 9, 1, 0, 9, 0, 1, 40'h0504030211));
    vecs.push_back(mk(1, 8'h13, 0, 0, 9, 1, 0, 9, 0, 1, 40'h0504031211));
    vecs.push_back(mk(1, 8'h14, 0, 0, 9, 1, 0, 9, 0, 1, 40'h0504131211));
    vecs.push_back(mk(1, 8'h15, 0, 0, 9, 1, 0, 9, 0, 1, 40'h0514131211));
    vecs.push_back(mk(1, 8'h16, 0, 0, 9, 1, 0, 9, 1, 1, 40'h1514131211));
    vecs.push_back(mk(1, 8'h17, 1, 0, 9, 1, 0, 9, 0, 1, 40'h1514131211));
    vecs.push_back(mk(0, 8'h00, 0, 0, 9, 1, 0, 9, 0, 0, 40'h1514131211));
    // frame after drain, class 17, left waiting in OUT
    vecs.push_back(mk(1, 8'h21, 0, 0, 17, 1, 0, 9, 0, 0, 40'h1514131211));
    vecs.push_back(mk(1, 8'h22, 0, 0, 17, 1, 0, 9, 0, 1, 40'h1514131221));
    vecs.push_back(mk(1, 8'h23, 0, 0, 17, 1, 0, 9, 0, 1, 40'h1514132221));
    vecs.push_back(mk(1, 8'h24, 0, 0, 17, 1, 0, 9, 0, 1, 40'h1514232221));
    vecs.push_back(mk(1, 8'h25, 1, 0, 17, 1, 0, 9, 0, 1, 40'h1524232221));
    vecs.push_back(mk(0, 8'h00, 0, 0, 17, 0, 0, 9, 0, 1, 40'h2524232221));
    vecs.push_back(mk(0, 8'h00, 0, 0, 17, 0, 1, 17, 0, 1, 40'h2524232221));

    rst = 1; s_valid = 0; s_data = 0; s_last = 0; m_ready = 0;
    tree_class = 0;
    rst_b = 1; s_valid_b = 0; s_data_b = 0; s_last_b = 0;
    m_ready_b = 0; tree_class_b = 0;
    @(negedge clk);
    step();
    rst = 0; rst_b = 0;

    for (int i = 0; i < vecs.size(); i++) begin
      s_valid = vecs[i].v; s_data = vecs[i].d; s_last = vecs[i].l;
      m_ready = vecs[i].mr; tree_class = vecs[i].tc;
      chk($sformatf("v%0d.s_ready", i), 64'(s_ready), 64'(vecs[i].sr));
      chk($sformatf("v%0d.m_valid", i), 64'(m_valid), 64'(vecs[i].mv));
      chk($sformatf("v%0d.m_class", i), 64'(m_class), 64'(vecs[i].mc));
      chk($sformatf("v%0d.err", i), 64'(err), 64'(vecs[i].er));
      chk($sformatf("v%0d.busy", i), 64'(busy), 64'(vecs[i].bz));
      chk($sformatf("v%0d.tree_feat", i), 64'(tree_feat),
          64'(vecs[i].feat));
      step();
    end

    // backpressure: result held while a new frame is offered
    tree_class = 5'd3;
    s_valid = 1; s_data = 8'h31; s_last = 0; m_ready = 0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp%0d.s_ready", i), 64'(s_ready), 64'd0);
      chk($sformatf("bp%0d.m_valid", i), 64'(m_valid), 64'd1);
      chk($sformatf("bp%0d.m_class", i), 64'(m_class), 64'd17);
      chk($sformatf("bp%0d.tree_feat", i), 64'(tree_feat),
          64'h2524232221);
      step();
    end
    m_ready = 1;
    step();
    m_ready = 0;
    chk("bp.m_valid_drop", 64'(m_valid), 64'd0);
    chk("bp.s_ready_back", 64'(s_ready), 64'd1);
    for (int k = 0; k < 5; k++) begin
      s_valid = 1; s_data = 8'h31 + 8'(k); s_last = (k == 4);
      step();
    end
    s_valid = 0; s_last = 0;
    chk("bp2.eval_m_valid", 64'(m_valid), 64'd0);
    step();
    chk("bp2.m_valid", 64'(m_valid), 64'd1);
    chk("bp2.m_class", 64'(m_class), 64'd3);
    chk("bp2.tree_feat", 64'(tree_feat), 64'h3534333231);
    m_ready = 1;
    step();
    m_ready = 0;
    chk("bp2.idle", 64'(busy), 64'd0);

`ifdef DTREE_SEQ_TIMEOUT_EN
    for (int k = 0; k < 2; k++) begin
      s_valid = 1; s_data = 8'h41 + 8'(k); s_last = 0;
      step();
    end
    s_valid = 0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("tmo_idle%0d.err", i), 64'(err), 64'd0);
      chk($sformatf("tmo_idle%0d.busy", i), 64'(busy), 64'd1);
      step();
    end
    chk("tmo.err_pulse", 64'(err), 64'd1);
    chk("tmo.cnt_cleared", 64'(busy), 64'd0);
    step();
    chk("tmo.err_single", 64'(err), 64'd0);
    tree_class = 5'd7;
    for (int k = 0; k < 5; k++) begin
      s_valid = 1; s_data = 8'h51 + 8'(k); s_last = (k == 4);
      step();
    end
    s_valid = 0; s_last = 0;
    step();
    chk("tmo.next_m_valid", 64'(m_valid), 64'd1);
    chk("tmo.next_m_class", 64'(m_class), 64'd7);
    chk("tmo.next_feat", 64'(tree_feat), 64'h5554535251);
    m_ready = 1;
    step();
    m_ready = 0;
`endif

    // TREE_LAT=4 latency: last beat in t, m_valid first in t+5
    tree_class_b = 5'd21;
    for (int k = 0; k < 5; k++) begin
      s_valid_b = 1; s_data_b = 8'h61 + 8'(k); s_last_b = (k == 4);
      step();
    end
    s_valid_b = 0; s_last_b = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("lat4_%0d.m_valid", i), 64'(m_valid_b), 64'd0);
      chk($sformatf("lat4_%0d.feat", i), 64'(tree_feat_b),
          64'h6564636261);
      step();
    end
    chk("lat4.m_valid", 64'(m_valid_b), 64'd1);
    chk("lat4.m_class", 64'(m_class_b), 64'd21);
    m_ready_b = 1;
    step();
    m_ready_b = 0;

    // reset on the second EVAL cycle
    for (int k = 0; k < 5; k++) begin
      s_valid_b = 1; s_data_b = 8'h71 + 8'(k); s_last_b = (k == 4);
      step();
    end
    s_valid_b = 0; s_last_b = 0;
    chk("rst.eval1_s_ready", 64'(s_ready_b), 64'd0);
    step();
    rst_b = 1;
    step();
    rst_b = 0;
    chk("rst.s_ready", 64'(s_ready_b), 64'd1);
    chk("rst.tree_feat", 64'(tree_feat_b), 64'd0);
    chk("rst.busy", 64'(busy_b), 64'd0);
    chk("rst.m_class", 64'(m_class_b), 64'd0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rst_hold%0d.m_valid", i), 64'(m_valid_b), 64'd0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
